// File: rtl/nexys_reset_sequencer.sv
// Nexys board reset sequencer: debounced reset button, SD-card power sequencing, SoC reset release.
// Define NEXYS_RSTSEQ_SD_POWER_CYCLE_EN to add the on-demand SD power-cycle path (SD_OFF/SD_REON).
module nexys_reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1000,
    parameter int unsigned SD_OFF_CYCLES    = 100000,
    parameter int unsigned SD_ON_CYCLES     = 100000,
    parameter int unsigned CORE_HOLD_CYCLES = 64
) (
    input  logic       ref_clk,
    input  logic       rst,
    input  logic       pad_reset_n_i,
    input  logic       sd_cycle_req_i,
    output logic       sd_cycle_ack_o,
    output logic       sdio_reset_o,
    output logic       core_rst_n_o,
    output logic       ready_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_SD_ON     = 3'd1,
        ST_CORE_HOLD = 3'd2,
`ifdef NEXYS_RSTSEQ_SD_POWER_CYCLE_EN
        ST_RUN       = 3'd3,
        ST_SD_OFF    = 3'd4,
        ST_SD_REON   = 3'd5
`else
        ST_RUN       = 3'd3
`endif
    } state_e;

    localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [19:0] ON_LAST   = 20'(SD_ON_CYCLES - 1);
    localparam logic [19:0] HOLD_LAST = 20'(CORE_HOLD_CYCLES - 1);

    logic        sync1_q, sync1_d, sync2_q, sync2_d;
    logic        pressed_q, pressed_d;
    logic [19:0] deb_cnt_q, deb_cnt_d;
    logic        req_q, req_d;
    state_e      state_q, state_d;
    logic [19:0] dur_q, dur_d;
    logic        sdio_reset_q, sdio_reset_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        ready_q, ready_d;

    // The synchronized pad is active-low, so equality with `pressed` means they disagree.
    always_comb begin
        sync1_d   = pad_reset_n_i;
        sync2_d   = sync1_q;
        pressed_d = pressed_q;
        deb_cnt_d = '0;
        if (sync2_q == pressed_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                pressed_d = ~pressed_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 20'd1;
            end
        end
    end

    assign req_d = sd_cycle_req_i;

`ifdef NEXYS_RSTSEQ_SD_POWER_CYCLE_EN
    localparam logic [19:0] OFF_LAST = 20'(SD_OFF_CYCLES - 1);

    logic req_edge;
    logic ack_q, ack_d;
    assign req_edge = sd_cycle_req_i & ~req_q;
`else
    logic unused_req_edge;
    assign unused_req_edge = sd_cycle_req_i & ~req_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:     if (!pressed_q) state_d = ST_SD_ON;
            ST_SD_ON:     if (dur_q == ON_LAST) state_d = ST_CORE_HOLD;
            ST_CORE_HOLD: if (dur_q == HOLD_LAST) state_d = ST_RUN;
`ifdef NEXYS_RSTSEQ_SD_POWER_CYCLE_EN
            ST_RUN:       if (req_edge) state_d = ST_SD_OFF;
            ST_SD_OFF:    if (dur_q == OFF_LAST) state_d = ST_SD_REON;
            ST_SD_REON:   if (dur_q == ON_LAST) state_d = ST_RUN;
`else
            ST_RUN:       state_d = ST_RUN;
`endif
            default:      state_d = ST_RESET;
        endcase
        // The debounced button overrides every other transition.
        if (pressed_q) state_d = ST_RESET;

        dur_d = '0;
        if (state_d == state_q && dur_q != '1) dur_d = dur_q + 20'd1;
        else if (state_d == state_q) dur_d = dur_q;

        // Outputs are decoded from the next state so they change on the same edge as the state.
`ifdef NEXYS_RSTSEQ_SD_POWER_CYCLE_EN
        sdio_reset_d = (state_d == ST_RESET) || (state_d == ST_SD_OFF);
        core_rst_n_d = (state_d == ST_RUN) || (state_d == ST_SD_OFF) || (state_d == ST_SD_REON);
        ack_d        = (state_q == ST_SD_REON) && (state_d == ST_RUN);
`else
        sdio_reset_d = (state_d == ST_RESET);
        core_rst_n_d = (state_d == ST_RUN);
`endif
        ready_d      = (state_d == ST_RUN);
    end

    // NOTE: reset is synchronous here, so it is just the first branch of the clocked block.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            pressed_q    <= 1'b1;
            deb_cnt_q    <= '0;
            req_q        <= 1'b1;
            state_q      <= ST_RESET;
            dur_q        <= '0;
            sdio_reset_q <= 1'b1;
            core_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            pressed_q    <= pressed_d;
            deb_cnt_q    <= deb_cnt_d;
            req_q        <= req_d;
            state_q      <= state_d;
            dur_q        <= dur_d;
            sdio_reset_q <= sdio_reset_d;
            core_rst_n_q <= core_rst_n_d;
            ready_q      <= ready_d;
        end
    end

`ifdef NEXYS_RSTSEQ_SD_POWER_CYCLE_EN
    always_ff @(posedge ref_clk) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= ack_d;
    end
    assign sd_cycle_ack_o = ack_q;
`else
    assign sd_cycle_ack_o = 1'b0;
`endif

    assign sdio_reset_o = sdio_reset_q;
    assign core_rst_n_o = core_rst_n_q;
    assign ready_o      = ready_q;
    assign state_o      = state_q;

endmodule
